// File: rtl/maze_pkg.sv
// Shared types and default parameters for the maze map SRAM arbiter.
package maze_pkg;

    localparam int          MAP_ADDR_W     = 10;
    localparam logic [31:0] BASE_ADR_DEF   = 32'h3000_0000;
    localparam logic [31:0] ADR_MASK_DEF   = 32'hFFFF_F000;
    localparam logic [31:0] UNMAP_DATA_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        RESP  = 2'd2,
        UNMAP = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_WB  = 1'b0,
        OWN_ENG = 1'b1
    } owner_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: bit 0 is Wishbone, bit 1 is the engine.
// On a tie the requester that did not win last time is granted.
module rr_arb2
    import maze_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    owner_t last_winner;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_winner <= OWN_ENG;
        end else if (update && (gnt != 2'b00)) begin
            last_winner <= gnt[1] ? OWN_ENG : OWN_WB;
        end
    end

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_winner == OWN_ENG) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/maze_mem_arbiter.sv
// Shares the single-port maze map SRAM between the Wishbone slave and the
// engine read port, one access per fixed 3-cycle slot.
//
//   state | meaning
//   IDLE  | arbitrate; register winner's command onto mem_* (mem_cs rises)
//   CMD   | SRAM command cycle, mem_cs high for exactly this cycle
//   RESP  | mem_rdata valid; route it to the owner, ack/rvalid next cycle
//   UNMAP | WB access outside the map window, ack with UNMAP_DATA
module maze_mem_arbiter
    import maze_pkg::*;
#(
    parameter int          ADDR_W     = MAP_ADDR_W,
    parameter logic [31:0] BASE_ADR   = BASE_ADR_DEF,
    parameter logic [31:0] ADR_MASK   = ADR_MASK_DEF,
    parameter logic [31:0] UNMAP_DATA = UNMAP_DATA_DEF
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic              eng_req,
    input  logic [ADDR_W-1:0] eng_addr,
    output logic              eng_gnt,
    output logic              eng_rvalid,
    output logic [31:0]       eng_rdata,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [3:0]        mem_wmask,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    arb_state_t state;
    arb_state_t state_nxt;
    owner_t     owner;
    logic       req_we;
    logic       wb_req;
    logic       wb_hit;
    logic       in_idle;
    logic       unmap_req;
    logic [1:0] arb_req;
    logic [1:0] arb_gnt;

    // The ack cycle itself never counts as a new request.
    assign wb_req    = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign wb_hit    = (wbs_adr_i & ADR_MASK) == BASE_ADR;
    assign in_idle   = (state == IDLE);
    assign unmap_req = in_idle & wb_req & ~wb_hit;
    assign arb_req   = (in_idle && !unmap_req) ? {eng_req, wb_req & wb_hit} : 2'b00;
    assign eng_gnt   = arb_gnt[1];

    rr_arb2 u_arb (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .req    (arb_req),
        .update (in_idle),
        .gnt    (arb_gnt)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (unmap_req)               state_nxt = UNMAP;
                else if (arb_gnt != 2'b00)   state_nxt = CMD;
            end
            CMD:     state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            UNMAP:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            owner      <= OWN_WB;
            req_we     <= 1'b0;
            mem_cs     <= 1'b0;
            mem_we     <= 1'b0;
            mem_wmask  <= 4'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            wbs_ack_o  <= 1'b0;
            wbs_dat_o  <= '0;
            eng_rvalid <= 1'b0;
            eng_rdata  <= '0;
        end else begin
            wbs_ack_o  <= 1'b0;
            eng_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_gnt[0]) begin
                        owner     <= OWN_WB;
                        req_we    <= wbs_we_i;
                        mem_cs    <= 1'b1;
                        mem_we    <= wbs_we_i;
                        mem_wmask <= wbs_we_i ? wbs_sel_i : 4'b0;
                        mem_addr  <= wbs_adr_i[ADDR_W+1:2];
                        mem_wdata <= wbs_dat_i;
                    end else if (arb_gnt[1]) begin
                        owner     <= OWN_ENG;
                        req_we    <= 1'b0;
                        mem_cs    <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_wmask <= 4'b0;
                        mem_addr  <= eng_addr;
                        mem_wdata <= '0;
                    end
                end
                CMD: begin
                    mem_cs    <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_wmask <= 4'b0;
                end
                RESP: begin
                    if (owner == OWN_ENG) begin
                        eng_rdata  <= mem_rdata;
                        eng_rvalid <= 1'b1;
                    end else if (wbs_cyc_i && wbs_stb_i) begin
                        // A master that abandoned its cycle gets nothing back.
                        wbs_dat_o <= req_we ? 32'h0 : mem_rdata;
                        wbs_ack_o <= 1'b1;
                    end
                end
                UNMAP: begin
                    wbs_dat_o <= UNMAP_DATA;
                    wbs_ack_o <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_maze_mem_arbiter.sv
// Bench for maze_mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of the map and arbitration.
module tb_maze_mem_arbiter;
    import maze_pkg::*;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] MASK = 32'hFFFF_F000;
    localparam int WB  = 0;
    localparam int ENG = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'h0, wdat = 32'h0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        eng_req = 1'b0;
    logic [9:0]  eng_addr = 10'h0;
    logic        eng_gnt, eng_rvalid;
    logic [31:0] eng_rdata;
    logic        mem_cs, mem_we;
    logic [3:0]  mem_wmask;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    maze_mem_arbiter dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .eng_req(eng_req), .eng_addr(eng_addr), .eng_gnt(eng_gnt),
        .eng_rvalid(eng_rvalid), .eng_rdata(eng_rdata),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_wmask(mem_wmask),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] init_word(input int i);
        logic [31:0] x;
        x = i;
        return (x * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // SRAM macro stand-in: read data one cycle after chip select.
    logic [31:0] sram [1024];
    logic        sram_ready = 1'b0;
    always @(posedge clk) begin
        if (!sram_ready) begin
            for (int i = 0; i < 1024; i++) sram[i] <= init_word(i);
            mem_rdata  <= 32'h0;
            sram_ready <= 1'b1;
        end else if (mem_cs) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wmask[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    // Reference model: map contents and who won the last arbitration.
    logic [31:0] ref_mem [1024];
    int          m_last = ENG;

    int          cyc_cnt = 0;
    int          cs_cyc[$];
    logic [9:0]  cs_adr[$];
    always @(posedge clk) begin
        cyc_cnt++;
        #2;
        if (mem_cs) begin
            cs_cyc.push_back(cyc_cnt);
            cs_adr.push_back(mem_addr);
        end
    end

    int          w_lat, w_cs_cnt, w_start;
    logic [31:0] w_rdata;
    logic        t1_cs, t1_we;
    logic [3:0]  t1_wmask;
    logic [9:0]  t1_addr;
    logic [31:0] t1_wdata;
    int          e_gnt_lat, e_rv_lat;
    logic [31:0] e_rdata;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_xfer(input logic pwe, input logic [31:0] padr, input logic [31:0] pdat,
                           input logic [3:0] psel);
        logic got;
        step();
        cyc = 1'b1; stb = 1'b1; we = pwe; adr = padr; wdat = pdat; sel = psel;
        w_start = cyc_cnt;
        got = 1'b0; w_lat = -1; w_cs_cnt = 0; w_rdata = 32'hx;
        for (int i = 1; i <= 12 && !got; i++) begin
            step();
            #1;
            if (mem_cs) w_cs_cnt++;
            if (i == 1) begin
                t1_cs = mem_cs; t1_we = mem_we; t1_wmask = mem_wmask;
                t1_addr = mem_addr; t1_wdata = mem_wdata;
            end
            if (wbs_ack_o) begin
                got = 1'b1; w_lat = i; w_rdata = wbs_dat_o;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic eng_read(input logic [9:0] a);
        step();
        eng_req = 1'b1; eng_addr = a;
        #1;
        e_gnt_lat = -1; e_rv_lat = -1; e_rdata = 32'hx;
        for (int i = 0; i <= 12 && e_rv_lat < 0; i++) begin
            if (i > 0) begin
                step();
                if (e_gnt_lat >= 0) eng_req = 1'b0;
                #1;
            end
            if (eng_gnt && e_gnt_lat < 0) e_gnt_lat = i;
            if (eng_rvalid) begin
                e_rv_lat = i; e_rdata = eng_rdata;
            end
        end
        eng_req = 1'b0;
    endtask

    task automatic wb_single(input logic pwe, input logic [31:0] padr, input logic [31:0] pdat,
                             input logic [3:0] psel, input string tag);
        logic hit;
        logic [9:0] wa;
        logic [31:0] exp_rd;
        int exp_lat;
        hit = (padr & MASK) == BASE;
        wa = padr[11:2];
        exp_lat = hit ? 3 : 2;
        exp_rd = (hit && !pwe) ? ref_mem[wa] : 32'h0;
        wb_xfer(pwe, padr, pdat, psel);
        if (hit && pwe) ref_mem[wa] = merge(ref_mem[wa], pdat, psel);
        if (hit) m_last = WB;
        n_tests++;
        if (w_lat !== exp_lat) begin
            n_fail++; $display("FAIL %s ack latency: got %0d exp %0d", tag, w_lat, exp_lat);
        end
        n_tests++;
        if (w_rdata !== exp_rd) begin
            n_fail++; $display("FAIL %s rdata: got %h exp %h", tag, w_rdata, exp_rd);
        end
        n_tests++;
        if (w_cs_cnt !== (hit ? 1 : 0)) begin
            n_fail++; $display("FAIL %s mem_cs cycles: got %0d exp %0d", tag, w_cs_cnt, hit ? 1 : 0);
        end
    endtask

    task automatic eng_single(input logic [9:0] a, input string tag);
        logic [31:0] exp_rd;
        exp_rd = ref_mem[a];
        eng_read(a);
        m_last = ENG;
        n_tests++;
        if (e_gnt_lat !== 0 || e_rv_lat !== 3) begin
            n_fail++;
            $display("FAIL %s eng timing: got gnt %0d rv %0d exp gnt 0 rv 3", tag, e_gnt_lat, e_rv_lat);
        end
        n_tests++;
        if (e_rdata !== exp_rd) begin
            n_fail++; $display("FAIL %s eng rdata: got %h exp %h", tag, e_rdata, exp_rd);
        end
    endtask

    // WB and engine request in the same cycle; the model decides who goes first.
    task automatic do_pair(input logic pwe, input logic [31:0] padr, input logic [31:0] pdat,
                           input logic [3:0] psel, input logic [9:0] pea, input string tag);
        logic wb_first;
        logic [9:0] wa;
        logic [31:0] exp_w, exp_e;
        wb_first = (m_last == ENG);
        wa = padr[11:2];
        exp_w = pwe ? 32'h0 : ref_mem[wa];
        if (pwe && wb_first) ref_mem[wa] = merge(ref_mem[wa], pdat, psel);
        exp_e = ref_mem[pea];
        if (pwe && !wb_first) ref_mem[wa] = merge(ref_mem[wa], pdat, psel);
        fork
            wb_xfer(pwe, padr, pdat, psel);
            eng_read(pea);
        join
        m_last = wb_first ? ENG : WB;
        n_tests++;
        if (w_lat !== (wb_first ? 3 : 6)) begin
            n_fail++; $display("FAIL %s wb ack latency: got %0d exp %0d", tag, w_lat, wb_first ? 3 : 6);
        end
        n_tests++;
        if (e_gnt_lat !== (wb_first ? 3 : 0) || e_rv_lat !== (wb_first ? 6 : 3)) begin
            n_fail++;
            $display("FAIL %s eng timing: got gnt %0d rv %0d exp gnt %0d rv %0d", tag,
                     e_gnt_lat, e_rv_lat, wb_first ? 3 : 0, wb_first ? 6 : 3);
        end
        n_tests++;
        if (w_rdata !== exp_w) begin
            n_fail++; $display("FAIL %s wb rdata: got %h exp %h", tag, w_rdata, exp_w);
        end
        n_tests++;
        if (e_rdata !== exp_e) begin
            n_fail++; $display("FAIL %s eng rdata: got %h exp %h", tag, e_rdata, exp_e);
        end
    endtask

    task automatic test_reset();
        repeat (3) step();
        #1;
        n_tests++;
        if ({wbs_ack_o, wbs_dat_o, eng_gnt, eng_rvalid, eng_rdata, mem_cs, mem_we,
             mem_wmask, mem_addr, mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset outputs: got ack %b dat %h cs %b addr %h exp all zero",
                     wbs_ack_o, wbs_dat_o, mem_cs, mem_addr);
        end
        rst = 1'b0;
        m_last = ENG;
    endtask

    task automatic test_wb_write();
        wb_single(1'b1, 32'h3000_0010, 32'hA5A5_1234, 4'hF, "wr_full");
        n_tests++;
        if ({t1_cs, t1_we, t1_wmask, t1_addr, t1_wdata} !== {1'b1, 1'b1, 4'hF, 10'd4, 32'hA5A5_1234}) begin
            n_fail++;
            $display("FAIL wr_full T1 cmd: got cs %b we %b mask %h addr %0d wdata %h exp 1 1 f 4 a5a51234",
                     t1_cs, t1_we, t1_wmask, t1_addr, t1_wdata);
        end
    endtask

    task automatic test_wb_read();
        wb_single(1'b0, 32'h3000_0010, 32'h0, 4'hF, "rd_back");
        n_tests++;
        if (w_rdata !== 32'hA5A5_1234 || t1_we !== 1'b0 || t1_wmask !== 4'h0) begin
            n_fail++;
            $display("FAIL rd_back: got data %h we %b mask %h exp a5a51234 0 0", w_rdata, t1_we, t1_wmask);
        end
        wb_single(1'b1, 32'h3000_0010, 32'h1122_3344, 4'h2, "wr_sel2");
        n_tests++;
        if (t1_wmask !== 4'h2) begin
            n_fail++; $display("FAIL wr_sel2 wmask: got %h exp 2", t1_wmask);
        end
        wb_single(1'b0, 32'h3000_0010, 32'h0, 4'hF, "rd_sel2");
        n_tests++;
        if (w_rdata !== 32'hA5A5_3334) begin
            n_fail++; $display("FAIL rd_sel2 merged word: got %h exp a5a53334", w_rdata);
        end
    endtask

    task automatic test_tie();
        step(); rst = 1'b1; step(); rst = 1'b0;
        m_last = ENG;
        cs_cyc.delete(); cs_adr.delete();
        do_pair(1'b0, 32'h3000_0008, 32'h0, 4'hF, 10'd7, "tie1");
        n_tests++;
        if (cs_cyc.size() != 2) begin
            n_fail++; $display("FAIL tie1 mem_cs count: got %0d exp 2", cs_cyc.size());
        end else if (cs_cyc[0] - w_start != 1 || cs_adr[0] !== 10'd2 ||
                     cs_cyc[1] - w_start != 4 || cs_adr[1] !== 10'd7) begin
            n_fail++;
            $display("FAIL tie1 mem slots: got T%0d@%0d T%0d@%0d exp T1@2 T4@7",
                     cs_cyc[0] - w_start, cs_adr[0], cs_cyc[1] - w_start, cs_adr[1]);
        end
        do_pair(1'b0, 32'h3000_0020, 32'h0, 4'hF, 10'd9, "tie2");
        wb_single(1'b1, 32'h3000_0030, 32'h0BAD_F00D, 4'hF, "pre_tie3");
        do_pair(1'b0, 32'h3000_0030, 32'h0, 4'hF, 10'd12, "tie3_eng");
    endtask

    task automatic test_eng_stream();
        logic [9:0] addrs [5];
        for (int k = 0; k < 5; k++) addrs[k] = 10'($urandom_range(0, 1023));
        step();
        eng_addr = addrs[0]; eng_req = 1'b1;
        #1;
        for (int c = 0; c <= 12; c++) begin
            if (c > 0) begin
                step();
                eng_addr = addrs[c/3];
                if (c == 12) eng_req = 1'b0;
                #1;
            end
            n_tests++;
            if (eng_gnt !== (c % 3 == 0 && c < 12) || mem_cs !== (c % 3 == 1) ||
                eng_rvalid !== (c >= 3 && c % 3 == 0)) begin
                n_fail++;
                $display("FAIL stream c%0d: got gnt %b cs %b rv %b", c, eng_gnt, mem_cs, eng_rvalid);
            end
            if (c >= 3 && c % 3 == 0) begin
                n_tests++;
                if (eng_rdata !== ref_mem[addrs[c/3-1]]) begin
                    n_fail++;
                    $display("FAIL stream rdata c%0d: got %h exp %h", c, eng_rdata, ref_mem[addrs[c/3-1]]);
                end
            end
        end
        m_last = ENG;
    endtask

    task automatic test_unmapped();
        wb_single(1'b0, 32'h3000_0010, 32'h0, 4'hF, "pre_unmap");
        wb_single(1'b0, 32'h3001_0000, 32'h0, 4'hF, "unmap_rd");
        wb_single(1'b1, 32'h3001_0010, 32'hDEAD_BEEF, 4'hF, "unmap_wr");
        wb_single(1'b0, 32'h3000_0010, 32'h0, 4'hF, "post_unmap");
    endtask

    task automatic test_reset_mid();
        int acks;
        step();
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0008; sel = 4'hF;
        step();
        #1;
        n_tests++;
        if (mem_cs !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid precondition: got cs %b exp 1", mem_cs);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if ({wbs_ack_o, wbs_dat_o, eng_rvalid, eng_rdata, mem_cs, mem_we, mem_wmask,
             mem_addr, mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid outputs: got cs %b addr %h dat %h exp zero", mem_cs, mem_addr, wbs_dat_o);
        end
        step();
        cyc = 1'b0; stb = 1'b0;
        step();
        rst = 1'b0;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            step(); #1;
            if (wbs_ack_o || mem_cs) acks++;
        end
        n_tests++;
        if (acks !== 0) begin
            n_fail++; $display("FAIL rst_mid stray activity: got %0d cycles exp 0", acks);
        end
        m_last = ENG;
        do_pair(1'b0, 32'h3000_0008, 32'h0, 4'hF, 10'd5, "post_rst_tie");
    endtask

    task automatic test_random();
        int op;
        logic [31:0] a;
        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 4);
            a = BASE | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
            case (op)
                0: wb_single(1'b1, a, $urandom, 4'($urandom_range(1, 15)), "rnd_wr");
                1: wb_single(1'b0, a, 32'h0, 4'hF, "rnd_rd");
                2: eng_single(10'($urandom_range(0, 31)), "rnd_eng");
                3: do_pair(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(1, 15)),
                           10'($urandom_range(0, 31)), "rnd_pair");
                default: begin
                    a = $urandom;
                    if ((a & MASK) == BASE) a = a ^ 32'h0000_1000;
                    wb_single(1'($urandom_range(0, 1)), a, $urandom, 4'hF, "rnd_unmap");
                end
            endcase
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
        test_reset();
        test_wb_write();
        test_wb_read();
        test_tie();
        test_eng_stream();
        test_unmapped();
        test_reset_mid();
        test_random();
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
